// File: rtl/pipe_run_ctrl_if.sv
// Debug-command, hazard and pipeline-control bundle between the debug/hazard logic and pipe_run_ctrl.
// The master drives the requests and hazards; the slave (controller) drives the pipeline controls.
interface pipe_run_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             run_req;
   logic             step_req;
   logic             clear_req;
   logic             halt_fetched;
   logic             load_use;
   logic             branch_taken;
   logic             pc_enable;
   logic             ifid_enable;
   logic             ifid_flush;
   logic             idex_flush;
   logic             pipe_enable;
   logic [2:0]       state;
   logic [CNT_W-1:0] cycle_count;
   logic             done;

   modport master (
      output run_req, step_req, clear_req, halt_fetched, load_use, branch_taken,
      input  pc_enable, ifid_enable, ifid_flush, idex_flush, pipe_enable,
             state, cycle_count, done
   );

   modport slave (
      input  run_req, step_req, clear_req, halt_fetched, load_use, branch_taken,
      output pc_enable, ifid_enable, ifid_flush, idex_flush, pipe_enable,
             state, cycle_count, done
   );
endinterface

// File: rtl/pipe_run_ctrl.sv
// Run/step/halt-drain controller for the 5-stage pipeline with load-use stall, branch flush and run-cycle counter.
// Define PIPE_CTRL_STEP_EN to build the single-step (STEP state / step_req) feature.
module pipe_run_ctrl #(
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 32
) (
   input  logic          clk,
   input  logic          reset,
   pipe_run_ctrl_if.slave bus
);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_STEP  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   logic [DW-1:0]    r_drain;
   logic [CNT_W-1:0] r_cycle_count;

   logic w_active;
   logic w_halt_take;
   logic w_pc_enable;
   logic w_ifid_enable;
   logic w_ifid_flush;
   logic w_idex_flush;
   logic w_pipe_enable;
   logic w_done;

   assign w_active    = (r_state == S_RUN) || (r_state == S_STEP);
   // A HALT coinciding with a load-use stall is held off; IF re-presents it next cycle.
   assign w_halt_take = w_active && bus.halt_fetched && !bus.load_use;

   // Pipeline control decode from current state and same-cycle hazard inputs.
   always_comb begin
      w_pc_enable   = 1'b0;
      w_ifid_enable = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_flush  = 1'b0;
      w_pipe_enable = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         S_RUN, S_STEP: begin
            w_pipe_enable = 1'b1;
            if (bus.load_use) begin
               w_idex_flush = 1'b1;
            end else begin
               w_pc_enable   = !bus.halt_fetched;
               w_ifid_enable = 1'b1;
               w_ifid_flush  = bus.branch_taken || bus.halt_fetched;
            end
         end
         S_DRAIN: begin
            w_pipe_enable = 1'b1;
            w_ifid_flush  = 1'b1;
         end
         S_DONE: begin
            w_done = 1'b1;
         end
         default: begin
            w_done = 1'b0;
         end
      endcase
   end

   // Mode sequencing, drain countdown and run-cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_drain       <= {DW{1'b0}};
         r_cycle_count <= {CNT_W{1'b0}};
      end else begin
         if (w_pipe_enable) begin
            r_cycle_count <= r_cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         case (r_state)
            S_IDLE: begin
               if (bus.run_req) begin
                  r_state <= S_RUN;
`ifdef PIPE_CTRL_STEP_EN
               end else if (bus.step_req) begin
                  r_state <= S_STEP;
`endif
               end
            end
            S_RUN: begin
               if (w_halt_take) begin
                  r_state <= S_DRAIN;
                  r_drain <= DW'(DRAIN_CYCLES - 1);
               end
            end
            S_STEP: begin
               if (w_halt_take) begin
                  r_state <= S_DRAIN;
                  r_drain <= DW'(DRAIN_CYCLES - 1);
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (r_drain == {DW{1'b0}}) begin
                  r_state <= S_DONE;
               end else begin
                  r_drain <= r_drain - {{(DW-1){1'b0}}, 1'b1};
               end
            end
            S_DONE: begin
               if (bus.clear_req) begin
                  r_state       <= S_IDLE;
                  r_cycle_count <= {CNT_W{1'b0}};
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.pc_enable   = w_pc_enable;
   assign bus.ifid_enable = w_ifid_enable;
   assign bus.ifid_flush  = w_ifid_flush;
   assign bus.idex_flush  = w_idex_flush;
   assign bus.pipe_enable = w_pipe_enable;
   assign bus.done        = w_done;
   assign bus.state       = r_state;
   assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed self-checking bench for pipe_run_ctrl; a second narrow-counter instance checks counter wrap.
module tb_pipe_run_ctrl;
   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;

   pipe_run_ctrl_if #(.CNT_W(32)) bus ();
   pipe_run_ctrl_if #(.CNT_W(2))  bus_w ();

   pipe_run_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   pipe_run_ctrl #(.DRAIN_CYCLES(1), .CNT_W(2)) dut_w (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_w)
   );

   assign bus_w.run_req      = bus.run_req;
   assign bus_w.step_req     = bus.step_req;
   assign bus_w.clear_req    = bus.clear_req;
   assign bus_w.halt_fetched = bus.halt_fetched;
   assign bus_w.load_use     = bus.load_use;
   assign bus_w.branch_taken = bus.branch_taken;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      if (obs !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset = 1'b1;
      bus.run_req = 1'b0; bus.step_req = 1'b0; bus.clear_req = 1'b0;
      bus.halt_fetched = 1'b0; bus.load_use = 1'b0; bus.branch_taken = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_cnt", bus.cycle_count, 32'd0);
      chk("rst_pc", 32'(bus.pc_enable), 32'd0);
      chk("rst_pipe", 32'(bus.pipe_enable), 32'd0);
      chk("rst_ifid_en", 32'(bus.ifid_enable), 32'd0);
      chk("rst_flush", 32'({bus.ifid_flush, bus.idex_flush}), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);

      // continuous run, no hazards
      bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("run_pc", 32'(bus.pc_enable), 32'd1);
         chk("run_pipe", 32'(bus.pipe_enable), 32'd1);
         chk("run_flush", 32'({bus.ifid_flush, bus.idex_flush}), 32'd0);
         tick();
      end
      chk("run_cnt", bus.cycle_count, 32'd10);
      chk("run_state", 32'(bus.state), 32'd1);
      chk("wrap_cnt", 32'(bus_w.cycle_count), 32'd2);

      // load-use stall for two cycles, branch ignored on the first
      bus.load_use = 1'b1; bus.branch_taken = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("lu_pc", 32'(bus.pc_enable), 32'd0);
         chk("lu_ifid_en", 32'(bus.ifid_enable), 32'd0);
         chk("lu_idex_flush", 32'(bus.idex_flush), 32'd1);
         chk("lu_ifid_flush", 32'(bus.ifid_flush), 32'd0);
         tick();
         bus.branch_taken = 1'b0;
      end
      bus.load_use = 1'b0;
      #1;
      chk("lu_end_pc", 32'(bus.pc_enable), 32'd1);
      chk("lu_end_idex", 32'(bus.idex_flush), 32'd0);
      chk("lu_cnt", bus.cycle_count, 32'd12);
      // taken branch without stall
      bus.branch_taken = 1'b1;
      #1;
      chk("br_flush", 32'(bus.ifid_flush), 32'd1);
      chk("br_pc", 32'(bus.pc_enable), 32'd1);
      tick();
      bus.branch_taken = 1'b0;

      // halt coinciding with load-use stays in RUN
      bus.halt_fetched = 1'b1; bus.load_use = 1'b1;
      #1;
      chk("hlu_pc", 32'(bus.pc_enable), 32'd0);
      chk("hlu_ifid_flush", 32'(bus.ifid_flush), 32'd0);
      tick();
      chk("hlu_state", 32'(bus.state), 32'd1);
      bus.load_use = 1'b0;

      // halt drain
      #1;
      chk("halt_pc", 32'(bus.pc_enable), 32'd0);
      chk("halt_ifid_flush", 32'(bus.ifid_flush), 32'd1);
      chk("halt_pipe", 32'(bus.pipe_enable), 32'd1);
      tick();
      bus.halt_fetched = 1'b0;
      chk("drain_enter_cnt", bus.cycle_count, 32'd15);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_state", 32'(bus.state), 32'd3);
         chk("drain_pc", 32'(bus.pc_enable), 32'd0);
         chk("drain_ifid_flush", 32'(bus.ifid_flush), 32'd1);
         chk("drain_pipe", 32'(bus.pipe_enable), 32'd1);
         chk("drain_done", 32'(bus.done), 32'd0);
         tick();
      end
      chk("done_state", 32'(bus.state), 32'd4);
      chk("done_flag", 32'(bus.done), 32'd1);
      chk("done_cnt", bus.cycle_count, 32'd19);
      tick(); tick();
      chk("done_frozen", bus.cycle_count, 32'd19);
      chk("done_pipe", 32'(bus.pipe_enable), 32'd0);

      // DONE ignores run_req, clear_req returns to IDLE
      bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
      chk("done_run_state", 32'(bus.state), 32'd4);
      chk("done_run_cnt", bus.cycle_count, 32'd19);
      bus.clear_req = 1'b1; tick(); bus.clear_req = 1'b0;
      chk("clr_state", 32'(bus.state), 32'd0);
      chk("clr_cnt", bus.cycle_count, 32'd0);
      chk("clr_done", 32'(bus.done), 32'd0);

      // single-step pulses at 5-cycle spacing
      for (int k = 0; k < 3; k++) begin
         bus.step_req = 1'b1;
         #1;
         chk("step_idle_pc", 32'(bus.pc_enable), 32'd0);
         tick();
         bus.step_req = 1'b0;
         #1;
`ifdef PIPE_CTRL_STEP_EN
         chk("step_state", 32'(bus.state), 32'd2);
         chk("step_pc", 32'(bus.pc_enable), 32'd1);
`else
         chk("nostep_state", 32'(bus.state), 32'd0);
         chk("nostep_pc", 32'(bus.pc_enable), 32'd0);
`endif
         tick();
         chk("step_back_state", 32'(bus.state), 32'd0);
         chk("step_back_pc", 32'(bus.pc_enable), 32'd0);
         tick(); tick(); tick();
      end
`ifdef PIPE_CTRL_STEP_EN
      chk("step_cnt", bus.cycle_count, 32'd3);
`else
      chk("nostep_cnt", bus.cycle_count, 32'd0);
`endif

      // reset mid-drain with drain counter at 2
      bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
      bus.halt_fetched = 1'b1; tick(); bus.halt_fetched = 1'b0;
      tick();
      chk("mid_drain_state", 32'(bus.state), 32'd3);
      reset = 1'b1; tick(); reset = 1'b0;
      #1;
      chk("rst2_state", 32'(bus.state), 32'd0);
      chk("rst2_cnt", bus.cycle_count, 32'd0);
      chk("rst2_pc", 32'(bus.pc_enable), 32'd0);
      chk("rst2_pipe", 32'(bus.pipe_enable), 32'd0);
      chk("rst2_flush", 32'({bus.ifid_flush, bus.idex_flush}), 32'd0);
      chk("rst2_done", 32'(bus.done), 32'd0);
      bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
      #1;
      chk("restart_state", 32'(bus.state), 32'd1);
      chk("restart_pc", 32'(bus.pc_enable), 32'd1);
      tick();
      chk("restart_cnt", bus.cycle_count, 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
Run/stall/flush controller for the 5-stage MIPS pipeline. Drives the PC register enable and the IF/ID and ID/EX pipeline-register controls. It sequences continuous run, single-step and halt-drain modes under debug-unit command, and applies load-use stalls and taken-branch flushes. It also keeps a run-cycle counter that the debug unit reports.

Parameters:
DRAIN_CYCLES, 4, cycles the back-end keeps running after a HALT is fetched, so that in-flight instructions retire.
CNT_W, 32, width of cycle_count.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
run_req  in  1  debug unit: start continuous run (1-cycle pulse).
step_req  in  1  debug unit: advance the pipeline exactly one cycle (1-cycle pulse).
clear_req  in  1  debug unit: return from DONE to IDLE and zero cycle_count.
halt_fetched  in  1  IF stage decoded the HALT opcode this cycle.
load_use  in  1  hazard unit: load-use hazard present in ID.
branch_taken  in  1  ID stage: branch/jump resolved taken.
pc_enable  out  1  enable for the PC register.
ifid_enable  out  1  IF/ID register write enable.
ifid_flush  out  1  IF/ID register synchronous clear (NOP insert).
idex_flush  out  1  ID/EX register synchronous clear (bubble).
pipe_enable  out  1  global enable for ID/EX, EX/MEM, MEM/WB.
state  out  3  current state encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4.
cycle_count  out  CNT_W  count of cycles with pipe_enable=1 since the last clear.
done  out  1  high while in DONE.

Behaviour:
- Reset (synchronous, active-high) has priority over every input and is effective mid-run. After reset: state=IDLE, cycle_count=0, drain counter=0. All enables are 0 and all flushes are 0.
- State and counters are registered. The control outputs are combinational from the current state and the hazard inputs, so they are valid in the same cycle as the inputs.
- IDLE:
  - All enables are 0.
  - run_req -> RUN.
  - step_req (without run_req) -> STEP.
  - If both are asserted, run_req wins.
- RUN:
  - pipe_enable=1.
  - Default outputs: pc_enable=1, ifid_enable=1, no flushes.
  - If load_use=1: pc_enable=0, ifid_enable=0, idex_flush=1, and branch_taken is ignored that cycle. The branch re-resolves after the stall.
  - Else if branch_taken=1: ifid_flush=1, and pc_enable stays 1.
  - If halt_fetched=1 and load_use=0: pc_enable=0 and ifid_flush=1 (HALT is not propagated), then go to DRAIN with the drain counter loaded to DRAIN_CYCLES-1.
  - If halt_fetched coincides with load_use, stay in RUN and stall; HALT is re-presented next cycle.
  - run_req and step_req are ignored in RUN.
- STEP:
  - Exactly one cycle of RUN outputs, with the same hazard, branch and halt rules.
  - Next state is IDLE, or DRAIN if HALT was taken that cycle.
- DRAIN:
  - pc_enable=0, ifid_enable=0, ifid_flush=1, pipe_enable=1.
  - The drain counter decrements each cycle; at 0 -> DONE.
  - load_use, branch_taken and halt_fetched are ignored.
- DONE:
  - All enables are 0; done=1.
  - clear_req -> IDLE, and cycle_count is zeroed on the same edge. Other requests are ignored.
- cycle_count:
  - Increments by 1 on every edge where pipe_enable=1.
  - Wraps from 2^CNT_W-1 to 0 without a flag.
  - clear_req is honoured only in DONE.
- Holding the PC is the only effect of pc_enable=0; the PC itself holds its value.

Optional Feature:
PIPE_CTRL_STEP_EN.
- Defined: STEP state and step_req are implemented as described.
- Undefined: step_req is ignored, the STEP encoding is never reached, and the IDLE->STEP transition is absent. All other behaviour is identical.

Test Plan:
- Reset, then run_req pulse, with no hazards for 10 cycles -> pc_enable=1 and pipe_enable=1 each cycle; cycle_count=10; state=1.
- In RUN, hold load_use=1 for 2 cycles with branch_taken=1 on the first of them -> pc_enable=0, ifid_enable=0, idex_flush=1 for exactly 2 cycles; ifid_flush=0 throughout; cycle_count still increments.
- In RUN, halt_fetched=1 with DRAIN_CYCLES=4 -> same cycle pc_enable=0 and ifid_flush=1; DRAIN for 4 cycles; done=1 on the 5th edge; cycle_count is frozen in DONE.
- In DONE, pulse run_req, then clear_req -> run_req has no effect; after clear_req, state=0 and cycle_count=0.
- With PIPE_CTRL_STEP_EN defined, pulse step_req 3 times at 5-cycle spacing from IDLE -> pc_enable high for exactly 3 single cycles; cycle_count=3; state returns to 0 after each step. With the macro undefined -> pc_enable stays 0 and cycle_count=0.
- Assert reset during DRAIN with the drain counter at 2 -> next edge: state=0, cycle_count=0, all outputs 0; a subsequent run_req restarts cleanly.
